counter_game_param: RTL

Parametrised multi-mode game counter. It merges the main up/down counter and the two win/lose tally counters into one block. It also adds configurable width, step size and tally limit, a count enable, and an explicit game-over state with a WHO code. A new game starts with `init`; no reset pulse is needed between games. It sits wherever the single 8-bit counter plus two 4-bit tallies were instantiated.

---
 rtl/counter_game_param.sv | 130 +++++++++++++
 1 files changed

// File: rtl/counter_game_param.sv
// counter_game_param: parametrised up/down game counter with win/lose tallies
// and an explicit game-over state. A game is started or restarted by `init`.
// `reset` is asynchronous and active-low. `state_dbg` exposes the FSM state:
// 0 = IDLE, 1 = RUN, 2 = OVER.
module counter_game_param #(
    parameter int WIDTH     = 8,
    parameter int TALLY_W   = 4,
    parameter int WIN_LIMIT = 15,
    parameter int STEP_BIG  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [WIDTH-1:0]   load,
    input  logic [1:0]         ctrl,
    input  logic               enable,
    output logic [WIDTH-1:0]   count,
    output logic               winner,
    output logic               loser,
    output logic [TALLY_W-1:0] win_tally,
    output logic [TALLY_W-1:0] lose_tally,
    output logic               gameover,
    output logic [1:0]         who,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   STEP_V  = WIDTH'(STEP_BIG);
    localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
    localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};
    localparam logic [TALLY_W-1:0] ONE_T   = TALLY_W'(1);
    localparam logic [TALLY_W-1:0] LIMIT_V = TALLY_W'(WIN_LIMIT);

    state_t             state, state_n;
    logic [WIDTH-1:0]   count_n;
    logic               winner_n, loser_n;
    logic [TALLY_W-1:0] win_n, lose_n;
    logic               gameover_n;
    logic [1:0]         who_n;

    logic [WIDTH-1:0]   step_mag;
    logic [WIDTH-1:0]   stepped;
    logic [TALLY_W-1:0] win_inc, lose_inc;

    // ctrl[0] selects the big step, ctrl[1] selects the count direction;
    // the arithmetic wraps modulo 2^WIDTH.
    assign step_mag  = ctrl[0] ? STEP_V : ONE_W;
    assign stepped   = ctrl[1] ? (count - step_mag) : (count + step_mag);
    assign win_inc   = win_tally + ONE_T;
    assign lose_inc  = lose_tally + ONE_T;
    assign state_dbg = state;

    // State and all outputs are registered so pulses line up with the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            winner     <= 1'b0;
            loser      <= 1'b0;
            win_tally  <= '0;
            lose_tally <= '0;
            gameover   <= 1'b0;
            who        <= 2'b00;
        end else begin
            state      <= state_n;
            count      <= count_n;
            winner     <= winner_n;
            loser      <= loser_n;
            win_tally  <= win_n;
            lose_tally <= lose_n;
            gameover   <= gameover_n;
            who        <= who_n;
        end
    end

    // Next state: init restarts the game from any state; only RUN counts.
    // Events compare the new count exactly, so a big step can skip a target.
    always_comb begin
        state_n    = state;
        count_n    = count;
        winner_n   = 1'b0;
        loser_n    = 1'b0;
        win_n      = win_tally;
        lose_n     = lose_tally;
        gameover_n = gameover;
        who_n      = who;
        if (init) begin
            state_n    = RUN;
            count_n    = load;
            win_n      = '0;
            lose_n     = '0;
            gameover_n = 1'b0;
            who_n      = 2'b00;
        end else begin
            case (state)
                IDLE: ;
                OVER: ;
                RUN: begin
                    if (enable) begin
                        count_n = stepped;
                        if (stepped == ONES_W) begin
                            winner_n = 1'b1;
                            win_n    = win_inc;
                            if (win_inc == LIMIT_V) begin
                                state_n    = OVER;
                                gameover_n = 1'b1;
                                who_n      = 2'b01;
                            end
                        end else if (stepped == '0) begin
                            loser_n = 1'b1;
                            lose_n  = lose_inc;
                            if (lose_inc == LIMIT_V) begin
                                state_n    = OVER;
                                gameover_n = 1'b1;
                                who_n      = 2'b10;
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
